// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative radix-2 multiply/divide unit owning the HI/LO register pair
// Ports: clk, rst (sync, active-high); start/op/a/b launch MULT, MULTU, DIV, DIVU;
// flush cancels an in-flight op; hi_wr/lo_wr/wdata implement mthi/mtlo;
// busy, done, div_by_zero report status; hi/lo are the result registers.
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t             state;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   bm;
    logic [2*WIDTH-1:0] acc;
    logic               sa;
    logic               sb;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic               ge;
    logic [2*WIDTH-1:0] step;
    logic [2*WIDTH-1:0] prod;
    assign busy = (state != IDLE);
    // acc holds {partial product | remainder, multiplier | dividend->quotient};
    // both operations shift one bit per step through the same register.
    always_comb begin
        sa    = ~op[0] & a[WIDTH-1];
        sb    = ~op[0] & b[WIDTH-1];
        mag_a = sa ? -a : a;
        mag_b = sb ? -b : b;
        sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, bm} : '0);
        diff  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, bm};
        ge    = ~diff[WIDTH];
        step  = is_div ? {(ge ? diff[WIDTH-1:0] : acc[2*WIDTH-2:WIDTH-1]), acc[WIDTH-2:0], ge}
                       : {sum, acc[WIDTH-1:1]};
        prod  = neg_q ? -acc : acc;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            if (hi_wr) hi <= wdata;
            if (lo_wr) lo <= wdata;
            if (flush) begin
                state <= IDLE;
            end else if (state == IDLE) begin
                if (start && op[1] && b == '0) begin
                    done        <= 1'b1;
                    div_by_zero <= 1'b1;
                end else if (start) begin
                    state  <= CALC;
                    is_div <= op[1];
                    neg_q  <= sa ^ sb;
                    neg_r  <= sa;
                    bm     <= mag_b;
                    acc    <= {{WIDTH{1'b0}}, mag_a};
                    cnt    <= '0;
                end
            end else if (state == CALC) begin
                acc   <= step;
                cnt   <= cnt + 1'b1;
                state <= (cnt == LAST) ? FIX : CALC;
            end else begin
                // The operation result overrides a same-edge mthi/mtlo write.
                state <= IDLE;
                done  <= 1'b1;
                hi    <= is_div ? (neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH]) : prod[2*WIDTH-1:WIDTH];
                lo    <= is_div ? (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]) : prod[WIDTH-1:0];
            end
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: scoreboard bench for muldiv_seq
module tb_muldiv_seq;
    localparam int W = 32;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic flush = 1'b0;
    logic hi_wr = 1'b0;
    logic lo_wr = 1'b0;
    logic [1:0] op = 2'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] wdata = '0;
    logic busy, done, div_by_zero;
    logic [W-1:0] hi, lo;
    int errors = 0;
    int checks = 0;
    int n, nb;
    logic prev_done = 1'b0;
    typedef struct packed {
        logic dbz;
        logic [W-1:0] h;
        logic [W-1:0] l;
    } exp_t;
    exp_t sb_q[$];
    exp_t e;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .hi_wr(hi_wr), .lo_wr(lo_wr), .wdata(wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2*W:0] got, input logic [2*W:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] p;
        logic [W-1:0] q, r;
        if (!o[1]) begin
            if (o[0]) p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
            else p = $signed({{W{x[W-1]}}, x}) * $signed({{W{y[W-1]}}, y});
            return {1'b0, p};
        end
        if (y == '0) return {1'b1, m_hi, m_lo};
        if (o[0]) begin
            q = x / y;
            r = x % y;
        end else if (x == {1'b1, {(W-1){1'b0}}} && y == '1) begin
            q = x;
            r = '0;
        end else begin
            q = $signed(x) / $signed(y);
            r = $signed(x) % $signed(y);
        end
        return {1'b0, r, q};
    endfunction

    // Monitor at posedge+1: pops the scoreboard on every done pulse.
    always @(posedge clk) begin
        #1;
        check("done_pulse", done & prev_done, 0);
        check("dbz_pulse", div_by_zero & ~done, 0);
        prev_done = done;
        if (done) begin
            check("done_expected", (sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("hi", hi, e.h);
                check("lo", lo, e.l);
                check("div_by_zero", div_by_zero, e.dbz);
                m_hi = e.h;
                m_lo = e.l;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        if (push) sb_q.push_back(model(o, x, y));
        tick();
        start = 1'b0;
        a = ~x;
        b = ~y;
        op = ~o;
    endtask

    task automatic wait_done(input int max, output int cyc, output int nbusy);
        cyc = 1;
        nbusy = 0;
        while (!done && cyc < max) begin
            if (busy) nbusy++;
            tick();
            cyc++;
        end
        check("done_seen", done, 1);
        check("busy_at_done", busy, 0);
    endtask

    logic [1:0]   t_op [6] = '{2'd1, 2'd0, 2'd2, 2'd2, 2'd3, 2'd0};
    logic [W-1:0] t_a  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'h80000000, 32'd7, 32'h7FFFFFFF};
    logic [W-1:0] t_b  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'd2, 32'h80000000};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tick();
        tick();
        check("reset_hilo", {hi, lo}, 0);
        check("reset_ctl", {busy, done, div_by_zero}, 0);
        rst = 1'b0;
        tick();
        start_op(2'd0, 32'hFFFFFFFD, 32'd5, 1);
        wait_done(W + 8, n, nb);
        check("mult_done_cycle", n, W + 2);
        check("mult_busy_cycles", nb, W + 1);
        for (int i = 0; i < 6; i++) begin
            start_op(t_op[i], t_a[i], t_b[i], 1);
            wait_done(W + 8, n, nb);
            check("op_done_cycle", n, W + 2);
        end
        tick();
        check("done_dropped", done, 0);
        hi_wr = 1'b1;
        wdata = 32'h11;
        tick();
        hi_wr = 1'b0;
        lo_wr = 1'b1;
        wdata = 32'h22;
        tick();
        lo_wr = 1'b0;
        m_hi = 32'h11;
        m_lo = 32'h22;
        check("preload", {hi, lo}, {32'h11, 32'h22});
        start_op(2'd3, 32'd7, 32'd0, 1);
        wait_done(W + 8, n, nb);
        check("dbz_done_cycle", n, 1);
        check("dbz_busy_cycles", nb, 0);
        tick();
        check("dbz_no_busy", busy, 0);
        start_op(2'd1, 32'd3, 32'd4, 0);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", busy, 0);
        check("flush_hilo", {hi, lo}, {m_hi, m_lo});
        start_op(2'd1, 32'd3, 32'd4, 1);
        wait_done(W + 8, n, nb);
        check("after_flush_cycle", n, W + 2);
        tick();
        hi_wr = 1'b1;
        wdata = 32'h55;
        start_op(2'd1, 32'd9, 32'd9, 1);
        hi_wr = 1'b0;
        check("write_with_start", hi, 32'h55);
        wait_done(W + 8, n, nb);
        start_op(2'd0, 32'h12345678, 32'hFFFFF000, 1);
        repeat (4) tick();
        op = 2'd2;
        a = 32'd100;
        b = 32'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (27) tick();
        check("busy_before_fix", busy, 1);
        hi_wr = 1'b1;
        wdata = 32'hAA;
        tick();
        hi_wr = 1'b0;
        check("fix_wins_done", done, 1);
        tick();
        start_op(2'd1, 32'hDEADBEEF, 32'h1234, 0);
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_hilo", {hi, lo}, 0);
        check("rst_mid_ctl", {busy, done, div_by_zero}, 0);
        m_hi = '0;
        m_lo = '0;
        repeat (W + 4) tick();
        check("rst_mid_idle", busy, 0);
        for (int i = 0; i < 10; i++) begin
            start_op(2'($urandom_range(3)), $urandom, (i == 4) ? 32'd0 : $urandom, 1);
            wait_done(W + 8, n, nb);
        end
        tick();
        check("scoreboard_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
